// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, memory-op encodings, FSM state encoding and
// the latched bus-request record used by the MEM pipeline stage.
package mem_stage_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LW   = 4'd3;
  localparam logic [3:0] MEM_LBU  = 4'd4;
  localparam logic [3:0] MEM_LHU  = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_e;

  // Everything the bus phase needs, captured at acceptance so upstream
  // can move on as soon as the ack arrives.
  typedef struct packed {
    logic [RegBus-1:0]     addr;
    logic [3:0]            memop;
    logic                  wreg;
    logic [RegAddrBus-1:0] wd;
    logic                  we;
    logic [3:0]            sel;
    logic [RegBus-1:0]     wdata;
  } bus_req_t;

  // Codes above MEM_SW are not memory ops and behave like MEM_NONE.
  function automatic logic memop_is_mem(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_SW);
  endfunction

  function automatic logic memop_is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational byte-lane logic for the MEM stage.
//   memop_i  : memory op code
//   off_i    : address byte offset (addr[1:0])
//   sdata_i  : raw store data      -> wdata_o : lane-replicated store data
//   rdata_i  : raw bus read data   -> rdata_o : extracted, extended load data
//   sel_o    : little-endian byte-lane enables
//   misalign_o : access does not fit its natural alignment
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]        memop_i,
  input  logic [1:0]        off_i,
  input  logic [RegBus-1:0] sdata_i,
  input  logic [RegBus-1:0] rdata_i,
  output logic [3:0]        sel_o,
  output logic [RegBus-1:0] wdata_o,
  output logic [RegBus-1:0] rdata_o,
  output logic              misalign_o
);

  logic [RegBus-1:0] rsh;
  assign rsh = rdata_i >> {off_i, 3'b000};

  always_comb begin
    sel_o      = 4'b0000;
    wdata_o    = sdata_i;
    rdata_o    = rdata_i;
    misalign_o = 1'b0;
    case (memop_i)
      MEM_LB, MEM_LBU, MEM_SB: begin
        sel_o   = 4'b0001 << off_i;
        wdata_o = {4{sdata_i[7:0]}};
        rdata_o = (memop_i == MEM_LB) ? {{24{rsh[7]}}, rsh[7:0]} : {24'd0, rsh[7:0]};
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        sel_o      = 4'b0011 << off_i;
        wdata_o    = {2{sdata_i[15:0]}};
        rdata_o    = (memop_i == MEM_LH) ? {{16{rsh[15]}}, rsh[15:0]} : {16'd0, rsh[15:0]};
        misalign_o = off_i[0];
      end
      MEM_LW, MEM_SW: begin
        sel_o      = 4'b1111;
        misalign_o = |off_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. ALU results pass straight to writeback;
// aligned loads/stores run one data-bus transaction (IDLE -> BUS -> IDLE)
// while stalling upstream; misaligned accesses raise a one-cycle pulse.
//   ex_*       : instruction in the EX slot (held by upstream while stalled)
//   flush      : discard the EX-slot instruction
//   stall_req  : upstream hold
//   dbus_*     : single-outstanding data bus, one-cycle ack
//   wb_*       : registered register-file write port
//   misalign*  : registered fault pulse with faulting address
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [3:0]            ex_memop,
  input  logic [RegBus-1:0]     ex_addr,
  input  logic [RegBus-1:0]     ex_sdata,
  input  logic                  ex_wreg,
  input  logic [RegAddrBus-1:0] ex_wd,
  input  logic [RegBus-1:0]     ex_wdata,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [RegBus-1:0]     dbus_addr,
  output logic [RegBus-1:0]     dbus_wdata,
  output logic [3:0]            dbus_sel,
  input  logic                  dbus_ack,
  input  logic [RegBus-1:0]     dbus_rdata,
  output logic                  wb_we,
  output logic [RegAddrBus-1:0] wb_waddr,
  output logic [RegBus-1:0]     wb_wdata,
  output logic                  misalign,
  output logic [RegBus-1:0]     misalign_addr
);

  state_e                state_q, state_d;
  bus_req_t              req_q, req_d;
  logic                  flushed_q, flushed_d;
  logic                  wb_we_q, wb_we_d;
  logic [RegAddrBus-1:0] wb_waddr_q, wb_waddr_d;
  logic [RegBus-1:0]     wb_wdata_q, wb_wdata_d;
  logic                  mis_q, mis_d;
  logic [RegBus-1:0]     mis_addr_q, mis_addr_d;
  logic                  stall_c;

  // One align unit: in IDLE it looks at the EX slot (sel/lanes/misalign),
  // in BUS at the latched request (load extraction on ack).
  logic [3:0]        al_memop;
  logic [1:0]        al_off;
  logic [3:0]        al_sel;
  logic [RegBus-1:0] al_wdata, al_rdata;
  logic              al_misalign;

  assign al_memop = (state_q == BUS) ? req_q.memop     : ex_memop;
  assign al_off   = (state_q == BUS) ? req_q.addr[1:0] : ex_addr[1:0];

  mem_align u_align (
    .memop_i   (al_memop),
    .off_i     (al_off),
    .sdata_i   (ex_sdata),
    .rdata_i   (dbus_rdata),
    .sel_o     (al_sel),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata),
    .misalign_o(al_misalign)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    flushed_d  = flushed_q;
    wb_we_d    = 1'b0;
    wb_waddr_d = wb_waddr_q;
    wb_wdata_d = wb_wdata_q;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
    stall_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid && !flush) begin
          if (!memop_is_mem(ex_memop)) begin
            wb_we_d    = ex_wreg && (ex_wd != '0);
            wb_waddr_d = ex_wd;
            wb_wdata_d = ex_wdata;
          end else if (al_misalign) begin
            mis_d      = 1'b1;
            mis_addr_d = ex_addr;
          end else begin
            req_d = '{addr: ex_addr, memop: ex_memop, wreg: ex_wreg, wd: ex_wd,
                      we: memop_is_store(ex_memop), sel: al_sel, wdata: al_wdata};
            flushed_d = 1'b0;
            state_d   = BUS;
            stall_c   = 1'b1;
          end
        end
      end
      BUS: begin
        stall_c = !dbus_ack;
        // A flush seen at any point of the access (ack cycle included)
        // kills the load writeback; the bus cycle itself always finishes.
        if (flush) flushed_d = 1'b1;
        if (dbus_ack) begin
          state_d = IDLE;
          if (!req_q.we && !(flushed_q || flush)) begin
            wb_we_d    = req_q.wreg && (req_q.wd != '0);
            wb_waddr_d = req_q.wd;
            wb_wdata_d = al_rdata;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      flushed_q  <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      flushed_q  <= flushed_d;
      wb_we_q    <= wb_we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  // Stall is combinational from EX inputs, so hold it low while in reset.
  assign stall_req     = stall_c && !rst;
  assign dbus_req      = (state_q == BUS);
  assign dbus_we       = dbus_req && req_q.we;
  assign dbus_addr     = {req_q.addr[RegBus-1:2], 2'b00};
  assign dbus_sel      = req_q.sel;
  assign dbus_wdata    = req_q.wdata;
  assign wb_we         = wb_we_q;
  assign wb_waddr      = wb_waddr_q;
  assign wb_wdata      = wb_wdata_q;
  assign misalign      = mis_q;
  assign misalign_addr = mis_addr_q;

endmodule
